// File: rtl/whisky_regfile_sb_pkg.sv
// Shared constants and types for the whisky register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default data/select widths, register-index type, and the index
// of the hardwired zero register.
package whisky_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  // Index of the register that reads zero when ZERO_REG is enabled.
  localparam int unsigned ZERO_IDX = 0;

endpackage

// File: rtl/whisky_regfile_sb_if.sv
// Bundle of decode-side read/reserve signals and writeback write signals.
// Latency: n/a (wiring only).
// Backpressure: none; consumers stall themselves on busy_a/busy_b.
//
// master: decode/writeback side (drives selects, write, reserve).
// slave : register file (returns read data, busy flags, any_busy, rsv_err).
interface whisky_regfile_sb_if
  import whisky_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              we;
  logic [ADDR_W-1:0] sel_w;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] sel_a;
  logic [ADDR_W-1:0] sel_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              rsv;
  logic [ADDR_W-1:0] sel_rsv;
  logic              busy_a;
  logic              busy_b;
  logic              any_busy;
  logic              rsv_err;

  modport master (
    output we, sel_w, data_in, sel_a, sel_b, rsv, sel_rsv,
    input  data_a, data_b, busy_a, busy_b, any_busy, rsv_err
  );

  modport slave (
    input  we, sel_w, data_in, sel_a, sel_b, rsv, sel_rsv,
    output data_a, data_b, busy_a, busy_b, any_busy, rsv_err
  );

endinterface

// File: rtl/whisky_scoreboard.sv
// Per-register pending-write tracker: reserve sets, write clears.
// Latency: busy/any_busy/rsv_err update one cycle after the causing edge.
// Backpressure: none; double reserve is flagged via rsv_err, never stalled.
//
// Ports: clk, reset_n (async active-low); rsv/sel_rsv reserve request;
// we/sel_w write completion; busy vector, any_busy, rsv_err outputs.
module whisky_scoreboard
  import whisky_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rsv,
  input  logic [ADDR_W-1:0]        sel_rsv,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        sel_w,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     any_busy,
  output logic                     rsv_err
);

  localparam int NREGS = 1 << ADDR_W;

  logic             rsv_ok;
  logic [NREGS-1:0] busy_nxt;

  // Clear before set: a same-cycle write retires the older op, the reserve
  // belongs to the new one, so the bit ends up set.
  always_comb begin
    rsv_ok   = rsv && !((ZERO_REG != 0) && (sel_rsv == ADDR_W'(ZERO_IDX)));
    busy_nxt = busy;
    if (we)     busy_nxt[sel_w]   = 1'b0;
    if (rsv_ok) busy_nxt[sel_rsv] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      any_busy <= 1'b0;
      rsv_err  <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      any_busy <= |busy_nxt;
      // Error follows the pre-edge state, regardless of any same-cycle write.
      rsv_err  <= rsv_ok && busy[sel_rsv];
    end
  end

endmodule

// File: rtl/whisky_regfile_sb.sv
// Parametrised register file with optional zero register, write bypass and
// an in-flight-write scoreboard. Reads: 0 cycles; writes visible next cycle
// (same cycle with BYPASS). Backpressure: none; consumers stall on busy_a/b.
//
// Ports: clk, reset_n (async active-low), rf (slave modport: write port,
// two read ports with busy flags, reserve port, any_busy, rsv_err).
module whisky_regfile_sb
  import whisky_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  whisky_regfile_sb_if.slave rf
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic              wr_ok;
  logic              zero_a, zero_b;
  logic              fwd_a, fwd_b;

  // Writes to the zero register are dropped so it never holds a value.
  assign wr_ok = rf.we && !((ZERO_REG != 0) && (rf.sel_w == ADDR_W'(ZERO_IDX)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[rf.sel_w] <= rf.data_in;
    end
  end

  whisky_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .rsv      (rf.rsv),
    .sel_rsv  (rf.sel_rsv),
    .we       (rf.we),
    .sel_w    (rf.sel_w),
    .busy     (busy),
    .any_busy (rf.any_busy),
    .rsv_err  (rf.rsv_err)
  );

  // Priority: zero register, then forwarded write, then stored state.
  // A forwarded value also clears busy so the consumer can issue at once.
  always_comb begin
    zero_a = (ZERO_REG != 0) && (rf.sel_a == ADDR_W'(ZERO_IDX));
    zero_b = (ZERO_REG != 0) && (rf.sel_b == ADDR_W'(ZERO_IDX));
    fwd_a  = (BYPASS != 0) && rf.we && (rf.sel_w == rf.sel_a);
    fwd_b  = (BYPASS != 0) && rf.we && (rf.sel_w == rf.sel_b);

    rf.data_a = regs[rf.sel_a];
    rf.busy_a = busy[rf.sel_a];
    if (zero_a) begin
      rf.data_a = '0;
      rf.busy_a = 1'b0;
    end else if (fwd_a) begin
      rf.data_a = rf.data_in;
      rf.busy_a = 1'b0;
    end

    rf.data_b = regs[rf.sel_b];
    rf.busy_b = busy[rf.sel_b];
    if (zero_b) begin
      rf.data_b = '0;
      rf.busy_b = 1'b0;
    end else if (fwd_b) begin
      rf.data_b = rf.data_in;
      rf.busy_b = 1'b0;
    end
  end

endmodule

// File: tb/tb_whisky_regfile_sb.sv
// Bench for whisky_regfile_sb: default config, a no-bypass twin sharing the
// same stimulus, and a 32x16 config. Expected observations are queued when
// stimulus is driven and compared when sampled on the falling edge.
module tb_whisky_regfile_sb;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  whisky_regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) if0 ();
  whisky_regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) if1 ();
  whisky_regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) ifw ();

  // The no-bypass twin sees exactly the same inputs as the main instance.
  assign if1.we      = if0.we;
  assign if1.sel_w   = if0.sel_w;
  assign if1.data_in = if0.data_in;
  assign if1.sel_a   = if0.sel_a;
  assign if1.sel_b   = if0.sel_b;
  assign if1.rsv     = if0.rsv;
  assign if1.sel_rsv = if0.sel_rsv;

  whisky_regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .rf(if0));
  whisky_regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .rf(if1));
  whisky_regfile_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dutw (
    .clk(clk), .reset_n(reset_n), .rf(ifw));

  typedef struct packed {
    logic        we;
    logic [2:0]  sw;
    logic [15:0] din;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic        rsv;
    logic [2:0]  sr;
  } stim_t;

  // nda = data_a of the no-bypass twin
  typedef struct packed {
    logic [15:0] da;
    logic [15:0] db;
    logic [15:0] nda;
    logic        ba;
    logic        bb;
    logic        ab;
    logic        re;
  } obs_t;

  typedef struct packed {
    logic [31:0] da;
    logic [31:0] db;
    logic        ba;
    logic        bb;
    logic        ab;
    logic        re;
  } wobs_t;

  obs_t  exp_q [$];
  wobs_t wexp_q [$];

  function automatic stim_t S(logic we, logic [2:0] sw, logic [15:0] din,
                              logic [2:0] sa, logic [2:0] sb, logic rsv, logic [2:0] sr);
    return '{we, sw, din, sa, sb, rsv, sr};
  endfunction

  function automatic obs_t mk(logic [15:0] da, logic [15:0] db, logic [15:0] nda,
                              logic ba, logic bb, logic ab, logic re);
    return '{da, db, nda, ba, bb, ab, re};
  endfunction

  function automatic obs_t observe();
    return '{if0.data_a, if0.data_b, if1.data_a, if0.busy_a, if0.busy_b,
             if0.any_busy, if0.rsv_err};
  endfunction

  function automatic wobs_t wobserve();
    return '{ifw.data_a, ifw.data_b, ifw.busy_a, ifw.busy_b, ifw.any_busy, ifw.rsv_err};
  endfunction

  task automatic drive(input stim_t s);
    if0.we      = s.we;
    if0.sel_w   = s.sw;
    if0.data_in = s.din;
    if0.sel_a   = s.sa;
    if0.sel_b   = s.sb;
    if0.rsv     = s.rsv;
    if0.sel_rsv = s.sr;
  endtask

  task automatic wdrive(logic we, logic [3:0] sw, logic [31:0] din,
                        logic [3:0] sa, logic [3:0] sb, logic rsv, logic [3:0] sr);
    ifw.we = we; ifw.sel_w = sw; ifw.data_in = din;
    ifw.sel_a = sa; ifw.sel_b = sb; ifw.rsv = rsv; ifw.sel_rsv = sr;
  endtask

  task automatic test_reset();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, e;
    @(posedge clk); #1;
    reset_n = 1'b1;
    st.push_back(S(0, 0, 16'h0, 5, 7, 0, 0)); ex.push_back(mk(16'h0, 16'h0, 16'h0, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observe(); e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL reset[%0d]: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_write_zero();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, e;
    st.push_back(S(1, 3, 16'hBEEF, 3, 0, 0, 0)); ex.push_back(mk(16'hBEEF, 16'h0, 16'h0000, 0, 0, 0, 0));
    st.push_back(S(1, 0, 16'h1234, 3, 0, 0, 0)); ex.push_back(mk(16'hBEEF, 16'h0, 16'hBEEF, 0, 0, 0, 0));
    st.push_back(S(0, 0, 16'h0,    3, 0, 0, 0)); ex.push_back(mk(16'hBEEF, 16'h0, 16'hBEEF, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observe(); e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL write_zero[%0d]: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_scoreboard();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, e;
    st.push_back(S(0, 0, 16'h0,    4, 3, 1, 4)); ex.push_back(mk(16'h0,    16'hBEEF, 16'h0,    0, 0, 0, 0));
    st.push_back(S(0, 0, 16'h0,    4, 3, 0, 0)); ex.push_back(mk(16'h0,    16'hBEEF, 16'h0,    1, 0, 1, 0));
    st.push_back(S(1, 4, 16'h00AA, 4, 3, 0, 0)); ex.push_back(mk(16'h00AA, 16'hBEEF, 16'h0,    0, 0, 1, 0));
    st.push_back(S(0, 0, 16'h0,    4, 3, 0, 0)); ex.push_back(mk(16'h00AA, 16'hBEEF, 16'h00AA, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observe(); e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL scoreboard[%0d]: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, e;
    st.push_back(S(0, 0, 16'h0,    6, 6, 1, 6)); ex.push_back(mk(16'h0,    16'h0,    16'h0,    0, 0, 0, 0));
    st.push_back(S(1, 6, 16'h5555, 6, 3, 1, 6)); ex.push_back(mk(16'h5555, 16'hBEEF, 16'h0,    0, 0, 1, 0));
    st.push_back(S(0, 0, 16'h0,    6, 3, 0, 0)); ex.push_back(mk(16'h5555, 16'hBEEF, 16'h5555, 1, 0, 1, 1));
    st.push_back(S(1, 6, 16'h5555, 6, 3, 0, 0)); ex.push_back(mk(16'h5555, 16'hBEEF, 16'h5555, 0, 0, 1, 0));
    st.push_back(S(0, 0, 16'h0,    6, 3, 0, 0)); ex.push_back(mk(16'h5555, 16'hBEEF, 16'h5555, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observe(); e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL simultaneous[%0d]: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_err_zero();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, e;
    st.push_back(S(0, 0, 16'h0,    2, 0, 1, 2)); ex.push_back(mk(16'h0,    16'h0, 16'h0,    0, 0, 0, 0));
    st.push_back(S(0, 0, 16'h0,    2, 0, 1, 2)); ex.push_back(mk(16'h0,    16'h0, 16'h0,    1, 0, 1, 0));
    st.push_back(S(0, 0, 16'h0,    2, 0, 1, 0)); ex.push_back(mk(16'h0,    16'h0, 16'h0,    1, 0, 1, 1));
    st.push_back(S(0, 0, 16'h0,    2, 0, 0, 0)); ex.push_back(mk(16'h0,    16'h0, 16'h0,    1, 0, 1, 0));
    st.push_back(S(1, 2, 16'h0002, 2, 0, 0, 0)); ex.push_back(mk(16'h0002, 16'h0, 16'h0,    0, 0, 1, 0));
    st.push_back(S(0, 0, 16'h0,    2, 0, 0, 0)); ex.push_back(mk(16'h0002, 16'h0, 16'h0002, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observe(); e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL err_zero[%0d]: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_wide();
    wobs_t got, e;
    // cycle 0: write r15 with bypass, reserve r9
    @(posedge clk); #1;
    wdrive(1, 4'd15, 32'hDEADBEEF, 4'd15, 4'd9, 1, 4'd9);
    wexp_q.push_back('{32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    got = wobserve(); e = wexp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL wide[0]: got %h want %h", got, e); end
    // cycle 1: stored value, r9 busy
    @(posedge clk); #1;
    wdrive(0, 4'd0, 32'h0, 4'd15, 4'd9, 0, 4'd0);
    wexp_q.push_back('{32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    got = wobserve(); e = wexp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL wide[1]: got %h want %h", got, e); end
    // cycle 2: write to r0 dropped, reserve already-busy r9
    @(posedge clk); #1;
    wdrive(1, 4'd0, 32'hFFFFFFFF, 4'd0, 4'd15, 1, 4'd9);
    wexp_q.push_back('{32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    got = wobserve(); e = wexp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL wide[2]: got %h want %h", got, e); end
    // cycle 3: error pulse, r9 still busy
    @(posedge clk); #1;
    wdrive(0, 4'd0, 32'h0, 4'd15, 4'd9, 0, 4'd0);
    wexp_q.push_back('{32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1});
    @(negedge clk);
    got = wobserve(); e = wexp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL wide[3]: got %h want %h", got, e); end
  endtask

  task automatic test_async_reset();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, e;
    wobs_t wgot, we_;
    st.push_back(S(1, 1, 16'h7777, 1, 6, 1, 1)); ex.push_back(mk(16'h7777, 16'h5555, 16'h0,    0, 0, 0, 0));
    st.push_back(S(0, 0, 16'h0,    1, 6, 0, 0)); ex.push_back(mk(16'h7777, 16'h5555, 16'h7777, 1, 0, 1, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observe(); e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL async_pre[%0d]: got %h want %h", i, got, e);
      end
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    reset_n = 1'b0;
    exp_q.push_back(mk(16'h0, 16'h0, 16'h0, 0, 0, 0, 0));
    wexp_q.push_back('{32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    #1;
    got = observe(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL async_clear: got %h want %h", got, e); end
    wgot = wobserve(); we_ = wexp_q.pop_front(); tests++;
    if (wgot !== we_) begin fails++; $display("FAIL async_clear_wide: got %h want %h", wgot, we_); end
    // A write on an edge while reset is held must be lost.
    drive(S(1, 3, 16'h9999, 1, 6, 0, 0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(S(0, 0, 16'h0, 3, 1, 0, 0));
    exp_q.push_back(mk(16'h0, 16'h0, 16'h0, 0, 0, 0, 0));
    @(negedge clk);
    got = observe(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL async_write_lost: got %h want %h", got, e); end
  endtask

  initial begin
    drive(S(0, 0, 16'h0, 0, 0, 0, 0));
    wdrive(0, 4'd0, 32'h0, 4'd0, 4'd0, 0, 4'd0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_write_zero();
    test_scoreboard();
    test_simultaneous();
    test_err_zero();
    test_wide();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/whisky_regfile_sb.md
# whisky_regfile_sb

Parametrised general-purpose register file for the whisky core. It supersedes the fixed 8×16 file: data width, register count, zero-register behaviour and write-to-read bypass are all configurable. It adds an asynchronous active-low reset and a per-register scoreboard that tracks destinations with writes still in flight, such as multi-cycle loads. It sits between decode (read ports, reservations) and writeback (write port).

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, select width; NREGS = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never becomes busy
- BYPASS, 1, 1 = same-cycle write data forwarded to the read ports
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- we  in  1  write enable
- sel_w  in  ADDR_W  write register select
- data_in  in  DATA_W  write data
- sel_a, sel_b  in  ADDR_W  read-port selects
- data_a, data_b  out  DATA_W  read data (combinational)
- rsv  in  1  reserve: mark sel_rsv as pending-write
- sel_rsv  in  ADDR_W  register to reserve
- busy_a, busy_b  out  1  selected register has a pending write (combinational)
- any_busy  out  1  at least one busy bit set (registered)
- rsv_err  out  1  one-cycle pulse: reserve hit an already-busy register

## Operation
- Storage array: NREGS × DATA_W.
- Write: at the clk edge with we=1, regs[sel_w] <= data_in and busy[sel_w] <= 0.
- Read port x (a/b):
  - ZERO_REG=1 and sel_x=0: data_x = 0, busy_x = 0.
  - Otherwise, with BYPASS=1, we=1 and sel_w=sel_x: data_x = data_in and busy_x = 0. The consumer may issue using the forwarded value.
  - Otherwise: data_x = regs[sel_x], busy_x = busy[sel_x].
- Reserve: at the edge with rsv=1 and the target not ZERO_REG 0, busy[sel_rsv] <= 1.
  - If busy[sel_rsv] was already 1, rsv_err pulses high for the next cycle. The bit stays 1.
- Reserve and write to the same register in one cycle: the write completes the older operation and the reserve belongs to the new one, so data updates and busy ends at 1. rsv_err follows the pre-edge busy value.
- Reserve and write to different registers in one cycle: both take effect.
- Writing a non-busy register is legal (single-cycle ALU results). No error is raised.
- any_busy is a register equal to OR of the post-edge busy vector.
- Reset (reset_n=0, asynchronous):
  - all regs = 0, busy = 0, any_busy = 0, rsv_err = 0
  - data_a/data_b therefore read 0
- Reset asserted mid-operation discards pending reservations. A write on the edge coinciding with reset is lost.

## Timing
- Read latency 0: combinational from sel_x, regs, busy and (if BYPASS) we/sel_w/data_in.
- With BYPASS=0, a write becomes visible on the read ports the cycle after the edge.
- busy_x asserts the cycle after the rsv edge. There is no same-cycle forwarding of reserve.
- any_busy and rsv_err are valid one cycle after the causing edge.
- No handshake stalls inside the block; stall decisions belong to the consumer, using busy_a/busy_b.

## Structure
- Package whisky_pkg holds:
  - default DATA_W/ADDR_W constants
  - the register-index typedef
  - the ZERO_REG index constant (0)
- Sub-module whisky_scoreboard owns the busy vector, reserve/clear arbitration, any_busy and rsv_err. Its inputs are rsv, sel_rsv, we and sel_w; it exports the busy vector.
- The top level holds the data array, the zero/bypass read muxing, and the busy_x qualification.

## Test plan
- Reset then read: after reset_n 0→1, sel_a=5, sel_b=7 → data_a=0, data_b=0, busy_a=busy_b=0, any_busy=0.
- Write/read, ZERO_REG: write 0xBEEF to r3, then 0x1234 to r0 → next cycle sel_a=3 gives 0xBEEF; sel_b=0 gives 0. Also check the same-cycle bypass: BYPASS=1 shows 0xBEEF on port a in the write cycle; BYPASS=0 shows the old 0x0000.
- Scoreboard: rsv r4 → next cycle busy_a=1 (sel_a=4) and any_busy=1. Write 0x00AA to r4 → busy_a=0 in that cycle (BYPASS=1) with data_a=0x00AA. Next cycle any_busy=0.
- Simultaneous: r6 busy; same cycle we r6=0x5555 and rsv r6 → next cycle regs[6]=0x5555, busy[6]=1, rsv_err=1 for exactly one cycle.
- Error/zero: rsv r2 twice in consecutive cycles → rsv_err pulses once, after the second edge. rsv r0 with ZERO_REG=1 → busy stays 0, no error.
- Async reset mid-op: r1 busy and r1=0x7777, pull reset_n low between edges → all outputs 0 immediately, before the next clk edge. Sweep DATA_W=32, ADDR_W=4.
